// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit framer and the matching receiver.
//   uart_state_t : framer state encodings (3 bits)
//   PARITY_*     : values accepted by the PARITY_MODE parameter
//   LINE_IDLE    : level of an idle serial line
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: integer clock divider for the serial bit rate.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   clear   : hold the count at 0 (used while no frame is in progress)
//   bit_end : high on the last cycle of every CLKS_PER_BIT-cycle bit period
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one byte per valid/ready handshake into
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   data_in    : byte to send, sampled on the accept cycle only
//   data_valid : source has a byte available
//   tx_ready   : a byte can be accepted this cycle
//   serial_out : registered UART line, idles high
//   tx_busy    : frame in progress (START through STOP)
//   tx_done    : one-cycle pulse after the last stop bit
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  generate
    if (PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        CLKS_PER_BIT < 2 || CLKS_PER_BIT > 256) begin : g_param_check
      $error("uart_tx_framer: illegal parameter value");
    end
  endgenerate

  uart_state_t state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        stop_idx, stop_idx_next;
  logic        parity_bit, parity_next;
  logic        line_next;
  logic        bit_end;
  logic        accept;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  ((state == IDLE) || (state == DONE)),
    .bit_end(bit_end)
  );

  assign tx_ready = (state == IDLE) && !i_rst;
  assign accept   = data_valid && tx_ready;
  assign tx_busy  = state inside {START, DATA, PARITY, STOP};
  assign tx_done  = (state == DONE);

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    parity_next   = parity_bit;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next    = START;
          shreg_next    = data_in;
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
          parity_next   = (PARITY_MODE == PARITY_ODD) ? ~^data_in : ^data_in;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_next   = {1'b0, shreg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx == 1'(STOP_BITS - 1)) state_next = DONE;
          else stop_idx_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so serial_out stays a
    // register yet changes in the same cycle the state does.
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shreg_next[0];
      PARITY:  line_next = parity_next;
      default: line_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      serial_out <= LINE_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_next;
      serial_out <= line_next;
      shreg      <= shreg_next;
      bit_idx    <= bit_idx_next;
      stop_idx   <= stop_idx_next;
      parity_bit <= parity_next;
    end
  end

endmodule
